wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_if.sv | 31 +++
 rtl/wb_port_arbiter.sv | 88 ++++++++
 tb/tb_wb_port_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Signal bundle between the pipeline/long-latency unit and the register-file write arbiter.
// The arbiter is the slave; the environment driving requests is the master.
interface wb_port_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic        lu_issue;
    logic [4:0]  lu_issue_rd;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_wd;
    logic        lu_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        stall;
    logic        rf_we3;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;

    modport slave (
        input  wb_we, wb_rd, wb_wd, lu_issue, lu_issue_rd,
        input  lu_valid, lu_rd, lu_wd, rs1, rs2,
        output lu_ready, stall, rf_we3, rf_a3, rf_wd3
    );

    modport master (
        output wb_we, wb_rd, wb_wd, lu_issue, lu_issue_rd,
        output lu_valid, lu_rd, lu_wd, rs1, rs2,
        input  lu_ready, stall, rf_we3, rf_a3, rf_wd3
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port between pipeline writeback and a long-latency unit,
// tracking outstanding long-latency destinations and stalling decode on hazards or starvation.
module wb_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_port_arbiter_if.slave  bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic          wb_act;
    logic          lu_xfer;
    logic [31:1]   busy_reg;
    logic [31:1]   busy_next;
    logic [31:0]   busy_vec;
    logic [CW-1:0] starve_cnt_reg;
    logic [CW-1:0] starve_cnt_next;
    logic          hazard_rs1;
    logic          hazard_rs2;
    logic          hazard_waw;
    logic          starved;

    // x0 never has a busy entry; the zero bit keeps variable indexing in range.
    assign busy_vec = {busy_reg, 1'b0};

    function automatic logic pending(input logic [4:0] idx, input logic [31:0] bv,
                                     input logic xfer, input logic [4:0] xfer_rd);
        return (idx != 5'd0) && bv[idx] && !(xfer && (xfer_rd == idx));
    endfunction

    always_comb begin
        wb_act       = bus.wb_we && (bus.wb_rd != 5'd0);
        bus.lu_ready = !wb_act;
        lu_xfer      = bus.lu_valid && !wb_act;

        bus.rf_we3 = 1'b0;
        bus.rf_a3  = 5'd0;
        bus.rf_wd3 = 32'd0;
        if (wb_act) begin
            bus.rf_we3 = 1'b1;
            bus.rf_a3  = bus.wb_rd;
            bus.rf_wd3 = bus.wb_wd;
        end else if (lu_xfer) begin
            bus.rf_we3 = (bus.lu_rd != 5'd0);
            bus.rf_a3  = bus.lu_rd;
            bus.rf_wd3 = bus.lu_wd;
        end

        // A same-cycle transfer lands on the negedge write, so it does not block readers.
        hazard_rs1 = pending(bus.rs1, busy_vec, lu_xfer, bus.lu_rd);
        hazard_rs2 = pending(bus.rs2, busy_vec, lu_xfer, bus.lu_rd);
        hazard_waw = bus.lu_issue && pending(bus.lu_issue_rd, busy_vec, lu_xfer, bus.lu_rd);
        starved    = (starve_cnt_reg == CW'(STARVE_MAX));
        bus.stall  = hazard_rs1 || hazard_rs2 || hazard_waw || starved;
    end

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit = bus.lu_issue && !bus.stall && (bus.lu_issue_rd == 5'(gi));
            assign clr_bit = lu_xfer && (bus.lu_rd == 5'(gi));
            // Set wins so a re-issue to the register being retired stays tracked.
            assign busy_next[gi] = set_bit ? 1'b1 : (clr_bit ? 1'b0 : busy_reg[gi]);
        end
    endgenerate

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (lu_xfer || !bus.lu_valid) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != CW'(STARVE_MAX)) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg       <= '0;
            starve_cnt_reg <= '0;
        end else begin
            busy_reg       <= busy_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed checks of wb_port_arbiter against a behavioural scoreboard model.
module tb_wb_port_arbiter;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    wb_port_arbiter_if bus();

    wb_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference state: which registers await a long-latency result, and how long it has waited.
    bit busy_m[32];
    int starve_m;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
        starve_m = 0;
    endtask

    function automatic bit blocked(input logic [4:0] r, input bit xfer, input logic [4:0] xrd);
        return (r != 0) && busy_m[r] && !(xfer && xrd == r);
    endfunction

    // Compare outputs against the model for the inputs now on the bus; optionally advance the model.
    task automatic eval_cycle(input string tag, input bit advance);
        bit act, rdy, xfer, e_stall;
        logic        e_we;
        logic [4:0]  e_a;
        logic [31:0] e_wd;
        act  = bus.wb_we && bus.wb_rd != 0;
        rdy  = !act;
        xfer = bus.lu_valid && rdy;
        if (act) begin
            e_we = 1'b1; e_a = bus.wb_rd; e_wd = bus.wb_wd;
        end else if (xfer) begin
            e_we = (bus.lu_rd != 0); e_a = bus.lu_rd; e_wd = bus.lu_wd;
        end else begin
            e_we = 1'b0; e_a = 5'd0; e_wd = 32'd0;
        end
        e_stall = blocked(bus.rs1, xfer, bus.lu_rd) || blocked(bus.rs2, xfer, bus.lu_rd)
               || (bus.lu_issue && blocked(bus.lu_issue_rd, xfer, bus.lu_rd))
               || (starve_m == STARVE_MAX);
        check_eq({tag, ".rf_we3"},   32'(bus.rf_we3),   32'(e_we));
        check_eq({tag, ".rf_a3"},    32'(bus.rf_a3),    32'(e_a));
        check_eq({tag, ".rf_wd3"},   bus.rf_wd3,        e_wd);
        check_eq({tag, ".lu_ready"}, 32'(bus.lu_ready), 32'(rdy));
        check_eq({tag, ".stall"},    32'(bus.stall),    32'(e_stall));
        $display("%s: wb=%0d/%0d lu=%0d/%0d iss=%0d/%0d rs=%0d,%0d -> we3=%0d a3=%0d rdy=%0d stall=%0d",
                 tag, bus.wb_we, bus.wb_rd, bus.lu_valid, bus.lu_rd, bus.lu_issue, bus.lu_issue_rd,
                 bus.rs1, bus.rs2, bus.rf_we3, bus.rf_a3, bus.lu_ready, bus.stall);
        if (advance) begin
            if (xfer && bus.lu_rd != 0) busy_m[bus.lu_rd] = 1'b0;
            if (bus.lu_issue && !e_stall && bus.lu_issue_rd != 0) busy_m[bus.lu_issue_rd] = 1'b1;
            if (xfer || !bus.lu_valid) starve_m = 0;
            else if (starve_m < STARVE_MAX) starve_m++;
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                         input logic iss, input logic [4:0] iss_rd,
                         input logic v, input logic [4:0] lrd, input logic [31:0] lwd,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.wb_we = we;  bus.wb_rd = rd;  bus.wb_wd = wd;
        bus.lu_issue = iss;  bus.lu_issue_rd = iss_rd;
        bus.lu_valid = v;  bus.lu_rd = lrd;  bus.lu_wd = lwd;
        bus.rs1 = r1;  bus.rs2 = r2;
    endtask

    task automatic step(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] wd,
                        input logic iss, input logic [4:0] iss_rd,
                        input logic v, input logic [4:0] lrd, input logic [31:0] lwd,
                        input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        drive(we, rd, wd, iss, iss_rd, v, lrd, lwd, r1, r2);
        #1;
        eval_cycle(tag, 1'b1);
    endtask

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        eval_cycle("reset", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write-port conflict: pipeline wins, unit drains in the following bubble.
        step("conf_issue", 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
        step("conf_wb",    1, 5, 32'hAAAA_0005, 0, 0, 1, 7, 32'h7777_0007, 0, 0);
        step("conf_lu",    0, 0, 0, 0, 0, 1, 7, 32'h7777_0007, 0, 0);
        step("conf_after", 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);

        // RAW on rs1 until the matching transfer bypasses it.
        step("raw_issue", 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        step("raw_wait0", 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        step("raw_wait1", 1, 2, 32'h22, 0, 0, 1, 3, 32'h33, 0, 3);
        step("raw_xfer",  0, 0, 0, 0, 0, 1, 3, 32'h33, 3, 0);

        // WAW with a simultaneous clear of the same register.
        step("waw_issue", 0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        step("waw_same",  0, 0, 0, 1, 9, 1, 9, 32'h99, 0, 0);
        step("waw_busy",  0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        step("waw_clear", 0, 0, 0, 0, 0, 1, 9, 32'h99, 0, 0);

        // Starvation: valid held against continuous writebacks.
        for (int i = 0; i < 6; i++)
            step($sformatf("starve%0d", i), 1, 1, 32'h1, 0, 0, 1, 0, 32'h0, 0, 0);
        step("starve_drain", 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0);
        step("starve_after", 1, 1, 32'h1, 0, 0, 0, 0, 0, 0, 0);

        // x0 on both sides.
        step("x0", 1, 0, 32'hDEAD, 0, 0, 1, 0, 32'hBEEF, 0, 0);

        // Reset mid-operation with busy[4] set and two blocked cycles counted.
        step("rst_issue", 0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
        step("rst_blk0",  1, 1, 32'h1, 0, 0, 1, 4, 32'h4, 4, 0);
        step("rst_blk1",  1, 1, 32'h1, 0, 0, 1, 4, 32'h4, 4, 0);
        @(negedge clk);
        drive(1, 1, 32'h1, 0, 0, 1, 4, 32'h4, 4, 4);
        rst_n = 1'b0;
        model_reset();
        #1;
        eval_cycle("rst_mid", 1'b0);
        #2;
        rst_n = 1'b1;
        step("rst_after", 0, 0, 0, 0, 0, 0, 0, 0, 4, 4);

        // Random traffic over a narrow register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            step($sformatf("rnd%0d", i),
                 logic'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                 logic'($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)),
                 logic'($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
